// File: rtl/fifo_rd_packer.sv
// Pops entries from a synchronous FIFO and packs PACK consecutive entries into one wide word
// on a valid/ready output; a flush pushes out a partially filled word with its lane count.
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          empty,
  input  logic [DATA_WIDTH-1:0]         fifo_data,
  output logic                          rd_en,
  input  logic                          flush,
  output logic [PACK*DATA_WIDTH-1:0]    out_data,
  output logic [$clog2(PACK+1)-1:0]     out_cnt,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int LW = $clog2(PACK);
  localparam int CW = $clog2(PACK+1);
  localparam int AW = (PACK-1)*DATA_WIDTH;
  localparam logic [LW-1:0] LAST_LANE = LW'(PACK-1);

  logic [LW-1:0]              r_rd_lane;
  logic [LW-1:0]              r_cap_lane;
  logic                       r_inflight;
  logic                       r_flush_pend;
  logic [AW-1:0]              r_asm;
  logic [PACK*DATA_WIDTH-1:0] r_out_data;
  logic [CW-1:0]              r_out_cnt;
  logic                       r_out_valid;

  logic          w_room;
  logic          w_cap_last;
  logic          w_flush_act;
  logic          w_flush_load;
  logic [AW-1:0] w_partial;

  assign w_room     = !r_out_valid || out_ready;
  // The last lane is only read when its word is guaranteed a free output register on arrival.
  assign rd_en      = rst_n && !empty && !r_flush_pend && ((r_rd_lane != LAST_LANE) || w_room);
  assign w_cap_last = r_inflight && (r_cap_lane == LAST_LANE);

  // A flush is serviced on its own edge if nothing is in flight and no read is being issued.
  assign w_flush_act  = (flush || r_flush_pend) && !r_inflight && !rd_en;
  assign w_flush_load = w_flush_act && (r_cap_lane != '0) && w_room;

  always_comb begin
    w_partial = '0;
    for (int i = 0; i < PACK-1; i++) begin
      if (LW'(i) < r_cap_lane) begin
        w_partial[i*DATA_WIDTH +: DATA_WIDTH] = r_asm[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_lane  <= '0;
      r_cap_lane <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= rd_en;
      if (w_flush_load) begin
        r_rd_lane  <= '0;
        r_cap_lane <= '0;
      end else begin
        if (rd_en) begin
          r_rd_lane <= (r_rd_lane == LAST_LANE) ? '0 : r_rd_lane + 1'b1;
        end
        if (r_inflight) begin
          r_cap_lane <= w_cap_last ? '0 : r_cap_lane + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_asm <= '0;
    end else if (r_inflight && !w_cap_last) begin
      for (int i = 0; i < PACK-1; i++) begin
        if (r_cap_lane == LW'(i)) begin
          r_asm[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_cnt   <= '0;
      r_out_valid <= 1'b0;
    end else if (w_cap_last) begin
      r_out_data  <= {fifo_data, r_asm};
      r_out_cnt   <= CW'(PACK);
      r_out_valid <= 1'b1;
    end else if (w_flush_load) begin
      r_out_data  <= {{DATA_WIDTH{1'b0}}, w_partial};
      r_out_cnt   <= CW'(r_cap_lane);
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_pend <= 1'b0;
    end else if (w_flush_act) begin
      r_flush_pend <= (r_cap_lane != '0) && !w_room;
    end else if (flush) begin
      r_flush_pend <= 1'b1;
    end
  end

  assign out_data  = r_out_data;
  assign out_cnt   = r_out_cnt;
  assign out_valid = r_out_valid;

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side consumer for the synchronous FIFO. It pops `DATA_WIDTH`-bit entries from the FIFO read port and packs `PACK` consecutive entries into one `PACK*DATA_WIDTH`-bit word. The word is presented on a valid/ready output with a lane count, and a flush forces out a partially filled word. It sits directly downstream of the FIFO and drives the FIFO's `rd_en`.

## Interface
- `DATA_WIDTH`, default 8: FIFO entry width.
- `PACK`, default 4: entries per output word; must be ≥ 2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `empty` in 1: FIFO empty flag.
- `fifo_data` in `DATA_WIDTH`: FIFO `data_out`. Valid the cycle after `rd_en` is sampled high.
- `rd_en` out 1: FIFO pop request.
- `flush` in 1: one-cycle pulse; emit any partial word.
- `out_data` out `PACK*DATA_WIDTH`: packed word. Lane 0 = bits `[DATA_WIDTH-1:0]` = oldest entry.
- `out_cnt` out `$clog2(PACK+1)`: number of valid lanes in `out_data` (1..`PACK`).
- `out_valid` out 1: output word valid.
- `out_ready` in 1: consumer accepts the word when `out_valid && out_ready` at a rising edge.

## Operation
**State**
- `rd_lane`: lane index of the next read issued, mod `PACK`.
- `cap_lane`: lane index of the next capture, mod `PACK`.
- `inflight`: `rd_en` was high last cycle. At most one read is outstanding.
- Assembly register: `PACK-1` lanes.
- Output register, plus `out_valid` and `out_cnt`.
- `flush_pend` flag.

**Room** = `!out_valid || out_ready` (the output register is free now or is being popped this edge).

**rd_en**
- Combinational. `rd_en = !empty && !flush_pend && (rd_lane != PACK-1 || room)`.
- Forced 0 while `rst_n` is low.

**Capture**
- When `inflight`, `fifo_data` is written to lane `cap_lane`, then `cap_lane` increments.
- If `cap_lane == PACK-1`, the full word (assembled lanes plus `fifo_data`) loads the output register. On that edge `out_valid` is set to 1, `out_cnt` to `PACK`, and `cap_lane` wraps to 0.
- The read-issue rule guarantees room on that edge.

**Output handshake**
- `out_valid && out_ready` with no load on the same edge: `out_valid` goes to 0.
- Accept and load on the same edge: the new word replaces the old and `out_valid` stays 1.
- `out_data` and `out_cnt` hold stable while `out_valid && !out_ready`.

**Flush**
- A `flush` pulse sets `flush_pend`; `rd_en` is held low while it is set.
- Once `!inflight`:
  - `cap_lane == 0`: clear `flush_pend`; no output.
  - `cap_lane > 0` and room: load the output register with the captured lanes, unused upper lanes zero. Set `out_cnt = cap_lane`, set `out_valid`, reset both lane pointers to 0, clear `flush_pend`.
  - `cap_lane > 0` and no room: wait.
- `flush` asserted while `flush_pend` is already set is ignored.

**Reset and boundaries**
- Reset mid-group discards assembled and in-flight data; packing restarts at lane 0.
- `rd_en` is never high while `empty` is high.

## Timing
- Reset values: `out_valid` 0, `out_data` 0, `out_cnt` 0, `rd_en` 0, pointers 0, `inflight` 0, `flush_pend` 0.
- Latency: first `rd_en` in cycle t; lane `PACK-1` read in t+`PACK`-1; its data arrives in t+`PACK`; `out_valid` rises in cycle t+`PACK`+1.
- Throughput: with `out_ready` held 1 and the FIFO non-empty, `rd_en` stays high every cycle, giving one word per `PACK` cycles with no bubble.
- `rd_en` responds combinationally to `empty` and `out_ready` in the same cycle.
- A flush with no in-flight read produces `out_valid` the cycle after the pulse, given room.

## Test plan
1. **Reset values.** Assert `rst_n=0` mid-run -> all outputs 0 immediately (asynchronous), before the next edge.
2. **Streaming.** FIFO preloaded with 0x11..0x88, `out_ready=1`, `PACK=4` -> `rd_en` high for 8 consecutive cycles. `out_data=0x44332211` then `0x88776655`, each with `out_cnt=4`. First `out_valid` 5 cycles after the first `rd_en`.
3. **Backpressure.** 12 entries, `out_ready=0` -> first word held stable. Lanes 0–2 of the second group are read, then `rd_en` drops. Raising `out_ready` re-asserts `rd_en` in the same cycle. No entry lost or duplicated: words are `0x44332211`, `0x88776655`, `0xCCBBAA99` for entries 0x11..0xCC.
4. **Partial flush.** Entries 0xA1, 0xA2, 0xA3, then `flush` -> `out_data=0x00A3A2A1`, `out_cnt=3`. The next word restarts at lane 0.
5. **Flush while empty.** `flush` with `cap_lane=0` -> no `out_valid`, pointers unchanged.
6. **Flush timing.** `flush` in the same cycle as a lane-1 `rd_en` -> the in-flight entry is captured first, then a 2-lane word is emitted (`out_cnt=2`).
